mm_stream_dma: RTL and testbench
================================

# mm_stream_dma

Host-side stream engine for the matrix-multiply accelerator's AXI-stream wrapper. It drives the accelerator's incoming operand stream (x) from a local source memory and drains its outgoing result stream (y) into a local destination memory. On completion it reports done, plus a sticky error on frame-length mismatch. It sits between on-chip BRAM buffers and the accelerator, replacing an external DMA in standalone test and deployment builds.

## Interface
- D_W, 32, stream and memory data width
- ADDR_W, 10, source/destination word-address width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- tx_len  in  ADDR_W+1  words to send (0..2^ADDR_W), latched at start
- rx_len  in  ADDR_W+1  words expected back, latched at start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err  out  1  sticky frame error; cleared by the next accepted start or by rst
- src_addr  out  ADDR_W  source read address
- src_en  out  1  source read enable; data is valid on src_rdata one cycle later
- src_rdata  in  D_W  source read data
- dst_addr  out  ADDR_W  destination write address
- dst_we  out  1  destination write enable
- dst_wdata  out  D_W  destination write data
- x_TDATA / x_TVALID / x_TLAST  out  D_W/1/1  operand stream to the accelerator
- x_TREADY  in  1
- y_TDATA / y_TLAST  in  D_W/1;  y_TVALID  in  1
- y_TREADY  out  1

## Operation
- Top FSM has three states: IDLE, RUN, DONE.
  - IDLE→RUN on start: latch the lengths, clear err, reset the TX and RX counters.
  - RUN→DONE when both the TX and RX engines have finished.
  - DONE→IDLE unconditionally after one cycle; done is high in DONE.
- start is ignored outside IDLE.
- TX engine:
  - Issues src reads at addresses 0..tx_len-1 into a 2-entry skid FIFO.
  - A read is issued only when the FIFO will have space, counting the in-flight read.
  - The FIFO head drives x_TDATA and x_TVALID.
  - x_TLAST=1 exactly on word tx_len-1.
  - TX finishes on the handshake of the last word. tx_len=0 finishes immediately and sends no beats.
- RX engine:
  - y_TREADY=1 throughout RUN while RX is unfinished.
  - Each y handshake is registered to dst: dst_addr=count, dst_wdata=y_TDATA, dst_we=1.
  - y_TLAST on word k<rx_len-1 (early): set err, write the word, finish RX.
  - y_TLAST absent on word rx_len-1: set err, finish RX. Later y beats are not accepted.
  - rx_len=0 finishes immediately and sets no err.
- Counters are ADDR_W+1 bits wide; addresses are the low ADDR_W bits. A full 2^ADDR_W transfer is legal and does not wrap early.
- rst at any time:
  - All outputs go to 0 in the next cycle, FSM returns to IDLE, and the FIFO and counters clear.
  - In-flight words are dropped with no TLAST.

## Timing
- Start is accepted in cycle 0.
  - Cycle 1: busy=1, src_en=1 with src_addr=0.
  - Cycle 2: first x_TVALID=1.
- With x_TREADY held high the engine sustains one word per cycle.
- Back-pressure on x_TREADY:
  - x_TVALID stays high, and x_TDATA/x_TLAST stay stable, until the handshake.
  - No read is lost or duplicated.
- x_TVALID never depends combinationally on x_TREADY.
- dst_we follows its y handshake by exactly one cycle.
- done pulses one cycle after the later of the final x handshake and the final dst_we. busy drops in the same cycle.
- TX and RX run concurrently; y beats may arrive before TX finishes.

## Structure
- Package mm_dma_pkg holds:
  - the top and engine state enums;
  - the LEN_W = ADDR_W+1 localparam convention;
  - the skid-FIFO depth constant (2).
- Sub-module mm_dma_skid: a 2-entry valid/ready FIFO with registered outputs, instantiated once in the TX path.

## Test plan
- tx_len=16, rx_len=4, ready always high, accelerator model returns 4 words with TLAST on the 4th:
  - 16 x beats in consecutive cycles 2..17, x_TLAST only on beat 15;
  - dst[0..3] written;
  - done pulses once, err=0.
- Random x_TREADY (50%), tx_len=33: exact sequence src[0..32] appears on x with no duplicates; TDATA is held stable while stalled.
- rx_len=8, model asserts TLAST on word 5: err=1, dst[0..5] written, y_TREADY=0 afterwards, done pulses.
- tx_len=0, rx_len=0: done pulses in cycle 2, no x beats, no dst writes, err=0.
- rst asserted mid-transfer (after 5 of 16 beats): next cycle all outputs 0 and busy=0. A fresh start then transfers all 16 words correctly.
- start pulsed again while busy: ignored, and the transfer count is unchanged.

Source files
------------

// File: rtl/mm_dma_pkg.sv
// Shared types and constants for the matrix-multiply stream DMA engine.
package mm_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } top_state_e;

    typedef enum logic {
        TX_STREAM = 1'b0,
        TX_FIN    = 1'b1
    } tx_state_e;

    typedef enum logic {
        RX_RECV = 1'b0,
        RX_FIN  = 1'b1
    } rx_state_e;

    localparam int SKID_DEPTH = 2;

    // Counters carry one extra bit so a full 2^ADDR_W transfer is representable.
    function automatic int len_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/mm_dma_skid.sv
// Two-entry valid/ready FIFO on the operand path; valid is decoded from flops only.
module mm_dma_skid
    import mm_dma_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [SKID_DEPTH];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         empty;
    logic         push;
    logic         pop;

    // An arriving word bypasses storage when the FIFO is empty and the sink takes it.
    assign empty       = (count_q == 2'd0);
    assign out_valid_o = in_valid_i || !empty;
    assign out_data_o  = empty ? in_data_i : mem_q[rd_ptr_q];
    assign pop         = !empty && out_ready_i;
    assign push        = in_valid_i && !(empty && out_ready_i);
    assign count_o     = count_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/mm_stream_dma.sv
// Streams operands from source BRAM to the accelerator and drains results into destination BRAM.
module mm_stream_dma
    import mm_dma_pkg::*;
#(
    parameter int D_W    = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   tx_len,
    input  logic [ADDR_W:0]   rx_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] src_addr,
    output logic              src_en,
    input  logic [D_W-1:0]    src_rdata,
    output logic [ADDR_W-1:0] dst_addr,
    output logic              dst_we,
    output logic [D_W-1:0]    dst_wdata,
    output logic [D_W-1:0]    x_TDATA,
    output logic              x_TVALID,
    output logic              x_TLAST,
    input  logic              x_TREADY,
    input  logic [D_W-1:0]    y_TDATA,
    input  logic              y_TLAST,
    input  logic              y_TVALID,
    output logic              y_TREADY
);

    localparam int LEN_W = len_w(ADDR_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    top_state_e        state_q;
    tx_state_e         tx_st_q;
    rx_state_e         rx_st_q;
    logic              err_q;
    logic [LEN_W-1:0]  tx_len_q;
    logic [LEN_W-1:0]  rx_len_q;
    logic [LEN_W-1:0]  rd_cnt_q;
    logic [LEN_W-1:0]  snt_cnt_q;
    logic [LEN_W-1:0]  rx_cnt_q;
    logic              inflight_q;
    logic              inflight_last_q;
    logic              dst_we_q;
    logic [ADDR_W-1:0] dst_addr_q;
    logic [D_W-1:0]    dst_wdata_q;

    logic [1:0]        skid_cnt;
    logic [1:0]        outstanding;
    logic              skid_vld;
    logic [D_W:0]      skid_word;
    logic              rd_last;
    logic              x_hs;
    logic              y_hs;
    logic              tx_fin_now;
    logic              rx_at_end;

    // A read is only issued if its word, plus any still in flight, fits in the FIFO.
    assign outstanding = skid_cnt + {1'b0, inflight_q};
    assign src_en      = (state_q == ST_RUN) && (tx_st_q == TX_STREAM) &&
                         (rd_cnt_q < tx_len_q) && (outstanding < 2'(SKID_DEPTH));
    assign src_addr    = rd_cnt_q[ADDR_W-1:0];
    assign rd_last     = (rd_cnt_q == tx_len_q - LEN_ONE);

    mm_dma_skid #(
        .W (D_W + 1)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (inflight_q),
        .in_data_i   ({inflight_last_q, src_rdata}),
        .out_valid_o (skid_vld),
        .out_data_o  (skid_word),
        .out_ready_i (x_TREADY),
        .count_o     (skid_cnt)
    );

    assign x_TVALID = skid_vld;
    assign x_TDATA  = skid_vld ? skid_word[D_W-1:0] : '0;
    assign x_TLAST  = skid_vld && skid_word[D_W];
    assign x_hs     = skid_vld && x_TREADY;

    // Finishing on the last handshake itself lets done follow it by a single cycle.
    assign tx_fin_now = (tx_st_q == TX_FIN) || (x_hs && (snt_cnt_q + LEN_ONE == tx_len_q));

    assign y_TREADY  = (state_q == ST_RUN) && (rx_st_q == RX_RECV);
    assign y_hs      = y_TVALID && y_TREADY;
    assign rx_at_end = (rx_cnt_q == rx_len_q - LEN_ONE);

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign dst_we    = dst_we_q;
    assign dst_addr  = dst_addr_q;
    assign dst_wdata = dst_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            tx_st_q         <= TX_FIN;
            rx_st_q         <= RX_FIN;
            err_q           <= 1'b0;
            tx_len_q        <= '0;
            rx_len_q        <= '0;
            rd_cnt_q        <= '0;
            snt_cnt_q       <= '0;
            rx_cnt_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            dst_we_q        <= 1'b0;
            dst_addr_q      <= '0;
            dst_wdata_q     <= '0;
        end else begin
            inflight_q      <= src_en;
            inflight_last_q <= src_en && rd_last;
            dst_we_q        <= y_hs;
            if (y_hs) begin
                dst_addr_q  <= rx_cnt_q[ADDR_W-1:0];
                dst_wdata_q <= y_TDATA;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        tx_len_q  <= tx_len;
                        rx_len_q  <= rx_len;
                        err_q     <= 1'b0;
                        rd_cnt_q  <= '0;
                        snt_cnt_q <= '0;
                        rx_cnt_q  <= '0;
                        tx_st_q   <= (tx_len == '0) ? TX_FIN : TX_STREAM;
                        rx_st_q   <= (rx_len == '0) ? RX_FIN : RX_RECV;
                    end
                end
                ST_RUN: begin
                    if (src_en) begin
                        rd_cnt_q <= rd_cnt_q + LEN_ONE;
                    end
                    if (x_hs) begin
                        snt_cnt_q <= snt_cnt_q + LEN_ONE;
                    end
                    if (tx_fin_now) begin
                        tx_st_q <= TX_FIN;
                    end
                    // A TLAST that disagrees with the expected frame end, either way, is a frame error.
                    if (y_hs) begin
                        rx_cnt_q <= rx_cnt_q + LEN_ONE;
                        if (y_TLAST != rx_at_end) begin
                            err_q <= 1'b1;
                        end
                        if (y_TLAST || rx_at_end) begin
                            rx_st_q <= RX_FIN;
                        end
                    end
                    if (tx_fin_now && (rx_st_q == RX_FIN)) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_stream_dma.sv
// Randomized bench for mm_stream_dma against a frame-level reference of the transfer.
module tb_mm_stream_dma;

    localparam int D_W    = 32;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   tx_len;
    logic [ADDR_W:0]   rx_len;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] src_addr;
    logic              src_en;
    logic [D_W-1:0]    src_rdata = '0;
    logic [ADDR_W-1:0] dst_addr;
    logic              dst_we;
    logic [D_W-1:0]    dst_wdata;
    logic [D_W-1:0]    x_TDATA;
    logic              x_TVALID;
    logic              x_TLAST;
    logic              x_TREADY;
    logic [D_W-1:0]    y_TDATA;
    logic              y_TLAST;
    logic              y_TVALID;
    logic              y_TREADY;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [D_W-1:0] src_mem [DEPTH];
    logic [D_W-1:0] ydat [64];

    always @(posedge clk) begin
        if (src_en) src_rdata <= src_mem[src_addr];
    end

    mm_stream_dma #(.D_W(D_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .tx_len    (tx_len),
        .rx_len    (rx_len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .src_addr  (src_addr),
        .src_en    (src_en),
        .src_rdata (src_rdata),
        .dst_addr  (dst_addr),
        .dst_we    (dst_we),
        .dst_wdata (dst_wdata),
        .x_TDATA   (x_TDATA),
        .x_TVALID  (x_TVALID),
        .x_TLAST   (x_TLAST),
        .x_TREADY  (x_TREADY),
        .y_TDATA   (y_TDATA),
        .y_TLAST   (y_TLAST),
        .y_TVALID  (y_TVALID),
        .y_TREADY  (y_TREADY)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One transfer: accelerator returns ny words with TLAST on index tl (-1: never).
    task automatic run_xfer(input int txl, input int rxl, input int ny, input int tl,
                            input int rdy_pct, input int rst_at, input int restart_at,
                            input bit strict);
        logic [D_W:0]      xq [$];
        int                xcyc [$];
        int                ycyc [$];
        int                wcyc [$];
        logic [ADDR_W-1:0] wa [$];
        logic [D_W-1:0]    wd [$];
        logic [D_W:0]      prev_word;
        int  t0, rel, yi, ndone, done_rel, nw, exp_done, lastx, lastw;
        bit  prev_stall, prev_busy, rst_pend, rst_chk, finished, exp_err;

        for (int i = 0; i < DEPTH; i++) src_mem[i] = $urandom;
        for (int i = 0; i < 64; i++) ydat[i] = $urandom;
        yi = 0; ndone = 0; done_rel = -1;
        prev_stall = 0; prev_busy = 0; rst_pend = 0; rst_chk = 0; finished = 0;
        prev_word = '0;

        @(negedge clk);
        start    = 1'b1;
        tx_len   = (ADDR_W+1)'(txl);
        rx_len   = (ADDR_W+1)'(rxl);
        x_TREADY = 1'b0;
        y_TVALID = 1'b0;
        t0       = cyc;

        for (int k = 0; k < 4000 && !finished; k++) begin
            @(negedge clk);
            rel      = cyc - t0;
            start    = (rel == restart_at);
            tx_len   = (ADDR_W+1)'($urandom);
            rx_len   = (ADDR_W+1)'($urandom);
            x_TREADY = ($urandom_range(99) < rdy_pct);
            rst      = 1'b0;
            if (yi < ny) begin
                y_TVALID = 1'b1;
                y_TDATA  = ydat[yi];
                y_TLAST  = (yi == tl);
            end else begin
                y_TVALID = 1'b0;
                y_TDATA  = '0;
                y_TLAST  = 1'b0;
            end
            if (rst_chk) begin
                #1;
                chk("rst_ctrl", {busy, done, err, src_en, dst_we, x_TVALID, x_TLAST, y_TREADY,
                                 src_addr, dst_addr}, 64'd0);
                chk("rst_data", {dst_wdata, x_TDATA}, 64'd0);
                return;
            end
            if (rst_pend) begin
                rst      = 1'b1;
                x_TREADY = 1'b0;
                y_TVALID = 1'b0;
                rst_chk  = 1'b1;
            end
            #1;
            if (rel == 1) begin
                chk("busy_c1", busy, 1);
                if (txl > 0) begin
                    chk("src_en_c1", src_en, 1);
                    chk("src_addr_c1", src_addr, 0);
                end
            end
            if (prev_stall) begin
                chk("hold_valid", x_TVALID, 1);
                chk("hold_word", {x_TLAST, x_TDATA}, prev_word);
            end
            prev_stall = x_TVALID && !x_TREADY;
            prev_word  = {x_TLAST, x_TDATA};
            if (x_TVALID && x_TREADY) begin
                xq.push_back({x_TLAST, x_TDATA});
                xcyc.push_back(rel);
            end
            if (y_TVALID && y_TREADY) begin
                ycyc.push_back(rel);
                yi++;
            end
            if (dst_we) begin
                wa.push_back(dst_addr);
                wd.push_back(dst_wdata);
                wcyc.push_back(rel);
            end
            if (done) begin
                ndone++;
                if (done_rel < 0) begin
                    done_rel = rel;
                    chk("busy_at_done", busy, 0);
                    chk("busy_before_done", prev_busy, 1);
                end
            end
            prev_busy = busy;
            if (rst_at > 0 && !rst_pend && xq.size() == rst_at) rst_pend = 1'b1;
            if (done_rel >= 0 && rel >= done_rel + 2) finished = 1'b1;
        end
        chk("timeout", finished, 1);

        // Reference: x carries src[0..txl-1], TLAST on the last; dst gets the frame up to its end.
        chk("x_count", xq.size(), txl);
        for (int i = 0; i < xq.size() && i < txl; i++)
            chk("x_word", xq[i], {(i == txl - 1), src_mem[i]});
        nw = (rxl == 0) ? 0 : ((tl >= 0 && tl < rxl) ? tl + 1 : rxl);
        exp_err = (rxl > 0) && (tl != rxl - 1);
        chk("y_accepted", ycyc.size(), nw);
        chk("dst_count", wa.size(), nw);
        for (int i = 0; i < wa.size() && i < nw; i++) begin
            chk("dst_addr", wa[i], i);
            chk("dst_data", wd[i], ydat[i]);
            if (i < ycyc.size()) chk("dst_lat", wcyc[i], ycyc[i] + 1);
        end
        chk("err", err, exp_err);
        chk("done_count", ndone, 1);
        lastx = (xcyc.size() > 0) ? xcyc[$] : -1;
        lastw = (wcyc.size() > 0) ? wcyc[$] : -1;
        exp_done = 2;
        if (lastx + 1 > exp_done) exp_done = lastx + 1;
        if (lastw + 1 > exp_done) exp_done = lastw + 1;
        chk("done_cycle", done_rel, exp_done);
        if (strict && txl > 0 && xcyc.size() == txl) begin
            chk("x_first_cycle", xcyc[0], 2);
            chk("x_last_cycle", xcyc[$], txl + 1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tx_len = '0; rx_len = '0;
        x_TREADY = 1'b0; y_TVALID = 1'b0; y_TDATA = '0; y_TLAST = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", {busy, done, err, src_en, dst_we, x_TVALID, y_TREADY}, 64'd0);
        rst = 1'b0;

        run_xfer(16, 4, 4, 3, 100, 0, -1, 1'b1);
        run_xfer(33, 3, 3, 2, 50, 0, -1, 1'b0);
        run_xfer(10, 8, 8, 5, 100, 0, -1, 1'b1);
        run_xfer(0, 0, 0, -1, 100, 0, -1, 1'b1);
        run_xfer(16, 4, 4, 3, 100, 5, -1, 1'b1);
        run_xfer(16, 4, 4, 3, 100, 0, -1, 1'b1);
        run_xfer(16, 4, 4, 3, 100, 0, 5, 1'b1);
        run_xfer(8, 5, 7, -1, 70, 0, -1, 1'b0);
        run_xfer(2, 6, 6, 5, 100, 0, -1, 1'b1);
        run_xfer(DEPTH, 2, 2, 1, 100, 0, -1, 1'b1);
        run_xfer(25, 6, 6, 5, 40, 0, 9, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
